// File: rtl/sdram_frame_fifo.sv
// sdram_frame_fifo: stages one pixel lane per SDRAM word and streams it to SRAM with raster write addresses.
module sdram_frame_fifo #(
  parameter int IN_W = 32,
  parameter int PIX_W = 16,
  parameter int LANE = 1,
  parameter int DEPTH = 64,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int PITCH = 800,
  parameter int ADDR_W = 20,
  parameter int AF_HI = 59,
  parameter int AF_LO = 32,
  parameter logic [PIX_W-1:0] SYNC_WORD = 16'hFFFF,
  parameter int SYNC_WINDOW = 40,
  parameter int SYNC_X = 33,
  parameter logic [ADDR_W-1:0] PARK_ADDR = 20'h5FFFF
) (
  input  logic                     CLOCK_100,
  input  logic                     Reset_h,
  input  logic                     new_frame,
  input  logic                     sdram_valid,
  input  logic [IN_W-1:0]          sdram_data_in,
  input  logic                     sram_wr_ready,
  output logic                     sram_wr_valid,
  output logic [PIX_W-1:0]         sram_data_out,
  output logic [ADDR_W-1:0]        sram_write_addr,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int XMAX = FRAME_W > SYNC_X + 1 ? FRAME_W : SYNC_X + 1;
  localparam int XW = XMAX > 1 ? $clog2(XMAX) : 1;
  localparam int YW = FRAME_H > 1 ? $clog2(FRAME_H) : 1;
  localparam int PCW = $clog2(FRAME_W * FRAME_H) + 1;
  typedef enum logic {FREE, FULL} af_t;
  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] occ_q, occ_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic done_q, done_d, ovf_q, ovf_d;
  af_t af_q, af_d;
  logic [PIX_W-1:0] head, lane;
  logic nempty, full, sync_head, valid, xfer, mpop, pop, push, x_last, y_last;
  logic unused_bits;
  assign unused_bits = ^sdram_data_in;
  assign lane = sdram_data_in[LANE*PIX_W +: PIX_W];
  always_comb begin
    head = mem_q[rd_ptr_q];
    nempty = occ_q != '0;
    full = occ_q == (AW+1)'(DEPTH);
    sync_head = head == SYNC_WORD && 32'(pc_q) < SYNC_WINDOW;
    valid = nempty && !done_q && !sync_head;
    xfer = valid && sram_wr_ready;
    mpop = nempty && sync_head;
    pop = xfer || mpop || (nempty && done_q);
    push = sdram_valid && (!full || pop);
    x_last = x_q == XW'(FRAME_W - 1);
    y_last = y_q == YW'(FRAME_H - 1);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d = push && !pop ? occ_q + 1'b1 : pop && !push ? occ_q - 1'b1 : occ_q;
    pc_d = pop && pc_q != '1 ? pc_q + 1'b1 : pc_q;
    ovf_d = ovf_q || (sdram_valid && full && !pop);
    // The last pixel of the frame freezes X/Y and raises frame_done instead of wrapping.
    x_d = mpop ? XW'(SYNC_X) : xfer && !x_last ? x_q + 1'b1 : xfer && !y_last ? '0 : x_q;
    y_d = mpop ? '0 : xfer && x_last && !y_last ? y_q + 1'b1 : y_q;
    done_d = done_q || (xfer && x_last && y_last);
    af_d = af_q == FREE ? (32'(occ_q) >= AF_HI ? FULL : FREE) : (32'(occ_q) < AF_LO ? FREE : FULL);
    if (new_frame) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d = '0;
      pc_d = '0;
      ovf_d = 1'b0;
      x_d = '0;
      y_d = '0;
      done_d = 1'b0;
      af_d = FREE;
    end
  end
  always_ff @(posedge CLOCK_100 or posedge Reset_h) begin
    if (Reset_h) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q <= '0;
      pc_q <= '0;
      ovf_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
      af_q <= FREE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q <= occ_d;
      pc_q <= pc_d;
      ovf_q <= ovf_d;
      x_q <= x_d;
      y_q <= y_d;
      done_q <= done_d;
      af_q <= af_d;
    end
  end
  always_ff @(posedge CLOCK_100) begin
    if (push && !new_frame) mem_q[wr_ptr_q] <= lane;
  end
  assign sram_wr_valid = valid;
  assign sram_data_out = head;
  assign sram_write_addr = valid ? ADDR_W'(PITCH * 32'(y_q) + 32'(x_q)) : PARK_ADDR;
  assign almost_full = af_q == FULL;
  assign overflow = ovf_q;
  assign frame_done = done_q;
  assign occupancy = occ_q;
endmodule

// File: tb/tb_sdram_frame_fifo.sv
// tb_sdram_frame_fifo: directed scenario tasks for sdram_frame_fifo with a reduced 128x4 frame.
module tb_sdram_frame_fifo;
  localparam int FW = 128;
  localparam int FH = 4;
  localparam logic [19:0] PARK = 20'h5FFFF;
  logic clk = 0, rst, nf, sv, rdy;
  logic [31:0] sd;
  logic valid, af, ovf, done;
  logic [15:0] dout;
  logic [19:0] addr;
  logic [6:0] occ;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sdram_frame_fifo #(.FRAME_W(FW), .FRAME_H(FH)) dut (
    .CLOCK_100(clk), .Reset_h(rst), .new_frame(nf), .sdram_valid(sv),
    .sdram_data_in(sd), .sram_wr_ready(rdy), .sram_wr_valid(valid),
    .sram_data_out(dout), .sram_write_addr(addr), .almost_full(af),
    .overflow(ovf), .frame_done(done), .occupancy(occ)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_frame();
    sv = 0; nf = 1;
    cyc();
    nf = 0;
  endtask
  task automatic test_reset();
    #3;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    checks++; if (addr !== PARK) begin errors++; $display("FAIL reset_addr got %h want %h", addr, PARK); end
    checks++; if (occ !== 7'd0 || af !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got occ=%0d af=%0b ovf=%0b done=%0b want 0", occ, af, ovf, done); end
    #9 rst = 0;
  endtask
  task automatic test_basic();
    logic [31:0] w [3];
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003;
    clear_frame();
    rdy = 1;
    for (int i = 0; i < 3; i++) begin
      sv = 1; sd = w[i];
      cyc();
      checks++; if (valid !== 1'b1 || dout !== w[i][31:16] || addr !== 20'(i)) begin errors++; $display("FAIL basic_px%0d got v=%0b d=%h a=%0d want 1 %h %0d", i, valid, dout, addr, w[i][31:16], i); end
    end
    sv = 0;
    cyc();
    checks++; if (occ !== 7'd0 || valid !== 1'b0 || addr !== PARK) begin errors++; $display("FAIL basic_idle got occ=%0d v=%0b a=%h want 0 0 %h", occ, valid, addr, PARK); end
  endtask
  task automatic test_almost_full();
    clear_frame();
    rdy = 0;
    for (int i = 0; i < 59; i++) begin
      sv = 1; sd = {16'(16'h0100 + i), 16'h0};
      cyc();
    end
    sv = 0;
    checks++; if (occ !== 7'd59 || af !== 1'b0) begin errors++; $display("FAIL af_reach got occ=%0d af=%0b want 59 0", occ, af); end
    cyc();
    checks++; if (af !== 1'b1) begin errors++; $display("FAIL af_assert got %0b want 1", af); end
    rdy = 1;
    for (int k = 0; k < 59; k++) begin
      checks++; if (valid !== 1'b1 || dout !== 16'(16'h0100 + k) || addr !== 20'(k)) begin errors++; $display("FAIL af_drain%0d got v=%0b d=%h a=%0d want 1 %h %0d", k, valid, dout, addr, 16'h0100 + k, k); end
      cyc();
      if (k == 26 || k == 27) begin
        checks++; if (af !== 1'b1) begin errors++; $display("FAIL af_hold occ=%0d got %0b want 1", occ, af); end
      end
      if (k == 28) begin
        checks++; if (af !== 1'b0) begin errors++; $display("FAIL af_release occ=%0d got %0b want 0", occ, af); end
      end
    end
  endtask
  task automatic test_overflow();
    clear_frame();
    rdy = 0;
    for (int i = 0; i < 65; i++) begin
      sv = 1; sd = {16'(16'h0200 + i), 16'h0};
      cyc();
      if (i == 63) begin
        checks++; if (occ !== 7'd64 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_full got occ=%0d ovf=%0b want 64 0", occ, ovf); end
      end
    end
    sv = 0;
    checks++; if (occ !== 7'd64 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got occ=%0d ovf=%0b want 64 1", occ, ovf); end
    rdy = 1;
    for (int k = 0; k < 64; k++) begin
      checks++; if (valid !== 1'b1 || dout !== 16'(16'h0200 + k)) begin errors++; $display("FAIL ovf_drain%0d got v=%0b d=%h want 1 %h", k, valid, dout, 16'h0200 + k); end
      cyc();
    end
    checks++; if (occ !== 7'd0 || valid !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_absent got occ=%0d v=%0b ovf=%0b want 0 0 1", occ, valid, ovf); end
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      sv = 1; sd = 32'h0777_0000;
      cyc();
    end
    nf = 1;
    cyc();
    nf = 0; sv = 0;
    checks++; if (occ !== 7'd0 || ovf !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL ovf_newframe got occ=%0d ovf=%0b v=%0b want 0 0 0", occ, ovf, valid); end
  endtask
  task automatic test_sync();
    clear_frame();
    rdy = 1; sv = 1; sd = 32'hFFFF_0000;
    cyc();
    checks++; if (valid !== 1'b0 || addr !== PARK || occ !== 7'd1) begin errors++; $display("FAIL sync_marker got v=%0b a=%h occ=%0d want 0 %h 1", valid, addr, occ, PARK); end
    sd = 32'h1234_0000;
    cyc();
    sv = 0;
    checks++; if (valid !== 1'b1 || dout !== 16'h1234 || addr !== 20'd33) begin errors++; $display("FAIL sync_realign got v=%0b d=%h a=%0d want 1 1234 33", valid, dout, addr); end
    cyc();
    checks++; if (occ !== 7'd0) begin errors++; $display("FAIL sync_drain got occ=%0d want 0", occ); end
  endtask
  task automatic test_frame();
    logic [19:0] exp_a;
    clear_frame();
    rdy = 1;
    for (int i = 0; i < FW * FH + 2; i++) begin
      sv = 1; sd = {16'(i + 1), 16'h0};
      cyc();
      if (i < FW * FH) begin
        exp_a = 20'((i / FW) * 800 + i % FW);
        checks++; if (valid !== 1'b1 || dout !== 16'(i + 1) || addr !== exp_a || done !== 1'b0) begin errors++; $display("FAIL frame_px%0d got v=%0b d=%h a=%0d done=%0b want 1 %h %0d 0", i, valid, dout, addr, done, 16'(i + 1), exp_a); end
      end else begin
        checks++; if (done !== 1'b1 || valid !== 1'b0 || addr !== PARK || occ !== 7'd1) begin errors++; $display("FAIL frame_post%0d got done=%0b v=%0b a=%h occ=%0d want 1 0 %h 1", i, done, valid, addr, occ, PARK); end
      end
      if (i == FW * FH - 1) begin
        checks++; if (addr !== 20'd2527) begin errors++; $display("FAIL frame_last got %0d want 2527", addr); end
      end
    end
    sv = 0;
    cyc();
    checks++; if (occ !== 7'd0 || done !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL frame_discard got occ=%0d done=%0b v=%0b want 0 1 0", occ, done, valid); end
  endtask
  task automatic test_async_reset();
    clear_frame();
    rdy = 1;
    for (int i = 0; i < 100; i++) begin
      sv = 1; sd = {16'(16'h0300 + i), 16'h0};
      cyc();
    end
    sv = 0;
    cyc();
    rdy = 0; sv = 1; sd = 32'h0400_0000;
    cyc();
    sv = 0;
    checks++; if (valid !== 1'b1 || addr !== 20'd100) begin errors++; $display("FAIL arst_pre got v=%0b a=%0d want 1 100", valid, addr); end
    #3 rst = 1;
    #1;
    checks++; if (valid !== 1'b0 || addr !== PARK || occ !== 7'd0 || af !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_now got v=%0b a=%h occ=%0d af=%0b ovf=%0b done=%0b want 0 %h 0 0 0 0", valid, addr, occ, af, ovf, done, PARK); end
    #1 rst = 0;
    rdy = 1; sv = 1; sd = 32'h0500_0000;
    cyc();
    sv = 0;
    checks++; if (valid !== 1'b1 || dout !== 16'h0500 || addr !== 20'd0) begin errors++; $display("FAIL arst_restart got v=%0b d=%h a=%0d want 1 0500 0", valid, dout, addr); end
    cyc();
  endtask
  initial begin
    rst = 1; nf = 0; sv = 0; rdy = 0; sd = '0;
    test_reset();
    test_basic();
    test_almost_full();
    test_overflow();
    test_sync();
    test_frame();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_frame_fifo.md
Name: sdram_frame_fifo

Overview:
Parametrised SDRAM-to-SRAM pixel staging FIFO. It accepts burst words from the SDRAM reader, extracts one pixel lane per word, and streams pixels to the SRAM writer with raster write addresses generated internally. Beyond the single-rate fixed buffer it adds:
- configurable geometry and depth
- a valid/ready output handshake
- almost-full hysteresis with programmable thresholds
- sticky overflow, frame-done and occupancy reporting
- start-of-frame sync-marker realignment

Parameters:
IN_W, 32, SDRAM word width
PIX_W, 16, pixel width; IN_W must be a multiple of PIX_W
LANE, 1, pixel lane taken from each input word: bits [LANE*PIX_W +: PIX_W]
DEPTH, 64, entries; power of two, >= 4
FRAME_W, 640, active pixels per line
FRAME_H, 480, active lines
PITCH, 800, SRAM address stride per line
ADDR_W, 20, SRAM address width
AF_HI, 59, occupancy at which almost_full asserts
AF_LO, 32, almost_full deasserts when occupancy < AF_LO; AF_LO < AF_HI <= DEPTH
SYNC_WORD, 16'hFFFF, sync marker pixel value
SYNC_WINDOW, 40, marker honoured only while pix_count < SYNC_WINDOW
SYNC_X, 33, X coordinate loaded on marker
PARK_ADDR, 20'h5FFFF, address driven while idle or done

Ports:
CLOCK_100  in  1  system clock
Reset_h  in  1  asynchronous active-high reset
new_frame  in  1  synchronous frame clear, one cycle
sdram_valid  in  1  input word present this cycle
sdram_data_in  in  IN_W  SDRAM word
sram_wr_ready  in  1  SRAM writer accepts a pixel this cycle
sram_wr_valid  out  1  pixel and address valid
sram_data_out  out  PIX_W  head pixel
sram_write_addr  out  ADDR_W  target address
almost_full  out  1  back-pressure to SDRAM reader
overflow  out  1  sticky, a push was dropped
frame_done  out  1  last pixel of frame written
occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset_h (async) and new_frame (sync) clear all state:
  - pointers 0, occupancy 0, X=Y=0, pix_count 0
  - almost_full 0, overflow 0, frame_done 0
  - storage contents need not clear
- Reset_h has priority over everything. new_frame has priority over push and pop in its cycle; a word arriving with new_frame is discarded.
- Push: sdram_valid && (occupancy < DEPTH || pop this cycle). The pixel lane is written at wr_ptr, which then increments modulo DEPTH.
- Overflow: sdram_valid && occupancy == DEPTH && no pop drops the word and sets overflow. Overflow holds until reset or new_frame.
- Head and output:
  - Head is show-ahead: sram_data_out = mem[rd_ptr] combinationally.
  - sram_write_addr = PITCH*Y + X, ADDR_W bits, computed combinationally from registered X and Y.
  - sram_write_addr = PARK_ADDR whenever sram_wr_valid = 0.
- sram_wr_valid = (occupancy != 0) && !frame_done && !sync_head, where sync_head = (head == SYNC_WORD) && pix_count < SYNC_WINDOW.
- Pop occurs on any of:
  - sram_wr_valid && sram_wr_ready (pixel transfer)
  - sync_head && occupancy != 0 (marker consumed internally, no SRAM write)
  - frame_done && occupancy != 0 (post-frame discard, one word per cycle)
- Pop advances rd_ptr modulo DEPTH and increments pix_count (saturating at its width max).
- Address advance on transfer:
  - X < FRAME_W-1: X+1.
  - Otherwise, Y < FRAME_H-1: X=0, Y+1.
  - Otherwise: frame_done=1; X and Y hold.
- Address on marker pop: X=SYNC_X, Y=0.
- occupancy: +1 on push only, -1 on pop only, unchanged when both or neither occur. It never exceeds DEPTH and never underflows.
- almost_full is a registered two-state FSM, FREE/FULL, updated from the registered occupancy:
  - FREE -> FULL when occupancy >= AF_HI.
  - FULL -> FREE when occupancy < AF_LO.
  - Output is 1 in FULL.
  - Reaction latency is one cycle after occupancy changes.
- Empty with sram_wr_ready high: no transfer, and X/Y hold.
- Pointer wrap at DEPTH-1 -> 0 is seamless; simultaneous push and pop at full or empty is legal.

Test Plan:
- Reset, then push 3 words 0xAAAA_0001, 0xBBBB_0002, 0xCCCC_0003 with sram_wr_ready=1 -> pixels 0xAAAA, 0xBBBB, 0xCCCC at addresses 0, 1, 2; occupancy returns to 0; sram_write_addr=0x5FFFF when idle.
- Hold sram_wr_ready=0 and push 59 words -> almost_full=1 on the cycle after occupancy reaches 59. Then drain with ready=1 -> almost_full=0 on the cycle after occupancy reaches 31.
- Push 65 words with ready=0, DEPTH=64 -> overflow=1, occupancy=64, 65th word absent from the output stream. Then pulse new_frame -> overflow=0, occupancy=0.
- First pushed word upper lane 0xFFFF, then 0x1234 -> marker consumed with no write; 0x1234 written at address 33.
- Stream FRAME_W*FRAME_H pixels -> last address 479*800+639=383839, frame_done=1; extra pushed words are discarded and sram_wr_valid stays 0.
- Assert Reset_h asynchronously mid-line with X=100 -> all outputs at reset values before the next clock edge; the following frame restarts at address 0.
